// File: rtl/bus_mem_pkg.sv
// Shared types and helpers for the bus memory responder: FSM state encoding,
// byte-lane geometry and the address-window rule.
package bus_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam int unsigned LAT_CNT_WIDTH = 4;

    function automatic int unsigned mask_width(input int unsigned data_width);
        return data_width / 8;
    endfunction

    function automatic int unsigned offset_bits(input int unsigned data_width);
        return $clog2(data_width / 8);
    endfunction

    // Operands are one bit wider than any supported address, so base + bytes
    // cannot wrap at the top of the address space.
    function automatic logic addr_in_window(
        input logic [64:0] addr,
        input logic [64:0] base,
        input logic [64:0] bytes
    );
        return (addr >= base) && (addr < base + bytes);
    endfunction

endpackage

// File: rtl/bus_mem_array.sv
// DEPTH x DATA_WIDTH word memory with per-byte write enables and a registered
// read port whose output holds between reads.
module bus_mem_array
    import bus_mem_pkg::*;
#(
    parameter int DEPTH      = 256,
    parameter int DATA_WIDTH = 32,
    parameter int IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [IDX_W-1:0]        wr_index,
    input  logic [DATA_WIDTH/8-1:0] wr_mask,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    rd_en,
    input  logic [IDX_W-1:0]        rd_index,
    output logic [DATA_WIDTH-1:0]   rd_data
);

    localparam int MASK_W = mask_width(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // NOTE: the storage array has no reset; clearing it would force flops
    // instead of RAM and contents must survive a bus reset anyway.
    always_ff @(posedge clk) begin
        for (int b = 0; b < MASK_W; b++) begin
            if (wr_en && wr_mask[b]) begin
                mem[wr_index][b*8 +: 8] <= wr_data[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_index];
        end
    end

endmodule

// File: rtl/bus_mem_responder.sv
// Memory-bus slave model: latency/stall FSM, address-window fault rule,
// byte-masked backing memory and request/fault statistics.
module bus_mem_responder
    import bus_mem_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE       = '0,
    parameter int                    LATENCY    = 1,
    parameter int                    WRITABLE   = 1,
    parameter int                    CNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   address_in,
    input  logic                    read_in,
    input  logic                    write_in,
    input  logic [DATA_WIDTH/8-1:0] write_mask_in,
    input  logic [DATA_WIDTH-1:0]   write_value_in,
    input  logic                    stall_in,
    output logic [DATA_WIDTH-1:0]   read_value_out,
    output logic                    ready_out,
    output logic                    fault_out,
    output logic [CNT_WIDTH-1:0]    req_count_out,
    output logic [CNT_WIDTH-1:0]    fault_count_out
);

    localparam int                       MASK_W       = mask_width(DATA_WIDTH);
    localparam int                       OFF_W        = offset_bits(DATA_WIDTH);
    localparam int                       IDX_W        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [64:0]              WINDOW_BYTES = 65'(DEPTH) * 65'(MASK_W);
    localparam logic [LAT_CNT_WIDTH-1:0] LAT_LOAD     = LAT_CNT_WIDTH'(LATENCY - 1);
    localparam bit                       READ_ONLY    = (WRITABLE == 0);

    state_t                   state, next_state;
    logic [LAT_CNT_WIDTH-1:0] lat_cnt, lat_cnt_next;
    logic                     req, in_window, fault_next, fault_q, resp_zero;
    logic                     enter_resp, ram_rd_en, ram_wr_en;
    logic [IDX_W-1:0]         word_index;
    logic [DATA_WIDTH-1:0]    ram_rd_data;
    logic [CNT_WIDTH-1:0]     req_cnt, fault_cnt;

    always_comb begin
        req        = read_in | write_in;
        in_window  = addr_in_window(65'(address_in), 65'(BASE), WINDOW_BYTES);
        word_index = IDX_W'((address_in - BASE) >> OFF_W);
        fault_next = !in_window || (read_in && write_in) || (write_in && READ_ONLY);
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        next_state   = state;
        lat_cnt_next = lat_cnt;
        unique case (state)
            IDLE: begin
                if (req) begin
                    lat_cnt_next = LAT_LOAD;
                    next_state   = (LATENCY == 1 && !stall_in) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (!req) begin
                    next_state = IDLE;
                end else if (!stall_in) begin
                    if (lat_cnt <= LAT_CNT_WIDTH'(1)) begin
                        next_state = RESP;
                    end else begin
                        lat_cnt_next = lat_cnt - LAT_CNT_WIDTH'(1);
                    end
                end
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // The array read is launched on the edge entering RESP so its registered
    // output is valid during the RESP cycle; writes land on the RESP edge.
    always_comb begin
        enter_resp = (next_state == RESP) && (state != RESP);
        ram_rd_en  = enter_resp && read_in && !fault_next;
        ram_wr_en  = (state == RESP) && write_in && !fault_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            lat_cnt   <= '0;
            fault_q   <= 1'b0;
            resp_zero <= 1'b0;
            req_cnt   <= '0;
            fault_cnt <= '0;
        end else begin
            state   <= next_state;
            lat_cnt <= lat_cnt_next;
            if (enter_resp) begin
                fault_q <= fault_next;
                if (fault_next) begin
                    resp_zero <= 1'b1;
                end else if (read_in) begin
                    resp_zero <= 1'b0;
                end
            end
            if (state == RESP) begin
                req_cnt <= req_cnt + CNT_WIDTH'(1);
                if (fault_q) begin
                    fault_cnt <= fault_cnt + CNT_WIDTH'(1);
                end
            end
        end
    end

    bus_mem_array #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_W      (IDX_W)
    ) u_array (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (ram_wr_en),
        .wr_index (word_index),
        .wr_mask  (write_mask_in),
        .wr_data  (write_value_in),
        .rd_en    (ram_rd_en),
        .rd_index (word_index),
        .rd_data  (ram_rd_data)
    );

    assign ready_out       = (state == RESP);
    assign fault_out       = ready_out && fault_q;
    assign read_value_out  = resp_zero ? '0 : ram_rd_data;
    assign req_count_out   = req_cnt;
    assign fault_count_out = fault_cnt;

endmodule
